// File: rtl/shift_pipeline_pkg.sv
// rtl/shift_pipeline_pkg.sv - shared defaults and width helpers for shift_pipeline
package shift_pipeline_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_DEPTH = 3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int span = 1; span < value; span = span * 2) begin
      result++;
    end
    return result;
  endfunction

  // A stage is stored packed as {data, valid}, valid in bit 0.
  function automatic int stage_bits(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one packed {data, valid} pipeline register with flush and enable
module shift_stage
  import shift_pipeline_pkg::*;
#(
  parameter int SW = stage_bits(DEFAULT_WIDTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          enable,
  input  logic [SW-1:0] d,
  output logic [SW-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_pipeline.sv
// rtl/shift_pipeline.sv - WIDTH x DEPTH delay line with valid, stall, flush and run-time tap
// Optional occupancy output enabled by SHIFT_PIPELINE_OCCUPANCY_EN.
module shift_pipeline
  import shift_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int TAP_W = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  input  logic             enable,
  input  logic             flush,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] op,
  output logic             op_valid
`ifdef SHIFT_PIPELINE_OCCUPANCY_EN
  ,
  output logic [clog2(DEPTH+1)-1:0] occupancy
`endif
);

  localparam int SW = stage_bits(WIDTH);

  // stage_q[0] is the first stage (fed from d), stage_q[DEPTH-1] the last.
  logic [SW-1:0] stage_q [DEPTH];
  logic [SW-1:0] tap_stage;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [SW-1:0] stage_d;
    if (k == 0) begin : g_head
      assign stage_d = {d, in_valid};
    end else begin : g_link
      assign stage_d = stage_q[k-1];
    end
    shift_stage #(.SW(SW)) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (flush),
      .enable  (enable),
      .d       (stage_d),
      .q       (stage_q[k])
    );
  end

  // Any tap_sel at or beyond the last stage falls through to the default.
  always_comb begin
    tap_stage = stage_q[DEPTH-1];
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (int'(tap_sel) == k) begin
        tap_stage = stage_q[k];
      end
    end
  end

  assign op       = tap_stage[SW-1:1];
  assign op_valid = tap_stage[0];

`ifdef SHIFT_PIPELINE_OCCUPANCY_EN
  localparam int OCC_W = clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else if (enable) begin
      occ_q <= occ_q + OCC_W'(in_valid) - OCC_W'(stage_q[DEPTH-1][0]);
    end
  end

  assign occupancy = occ_q;

  always_ff @(posedge clock) begin
    if (reset_n) begin
      occ_bound: assert (int'(occ_q) <= DEPTH);
    end
  end
`endif

endmodule

// File: tb/tb_shift_pipeline.sv
// tb/tb_shift_pipeline.sv - self-checking bench for shift_pipeline (8x4 and legacy 1x3 instances)
module tb_shift_pipeline;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic [7:0] a_d;
  logic       a_valid, a_en, a_flush;
  logic [1:0] a_tap;
  logic [7:0] a_op;
  logic       a_op_valid;
  logic       b_d, b_valid, b_en, b_flush;
  logic [1:0] b_tap;
  logic       b_op, b_op_valid;
`ifdef SHIFT_PIPELINE_OCCUPANCY_EN
  logic [2:0] a_occ;
  logic [1:0] b_occ;
`endif

  shift_pipeline #(.WIDTH(8), .DEPTH(4)) u_a (
    .clock    (clock),
    .reset_n  (reset_n),
    .d        (a_d),
    .in_valid (a_valid),
    .enable   (a_en),
    .flush    (a_flush),
    .tap_sel  (a_tap),
    .op       (a_op),
    .op_valid (a_op_valid)
`ifdef SHIFT_PIPELINE_OCCUPANCY_EN
    , .occupancy (a_occ)
`endif
  );

  shift_pipeline #(.WIDTH(1), .DEPTH(3)) u_b (
    .clock    (clock),
    .reset_n  (reset_n),
    .d        (b_d),
    .in_valid (b_valid),
    .enable   (b_en),
    .flush    (b_flush),
    .tap_sel  (b_tap),
    .op       (b_op),
    .op_valid (b_op_valid)
`ifdef SHIFT_PIPELINE_OCCUPANCY_EN
    , .occupancy (b_occ)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic [7:0] dd, input logic vv, input logic en,
                         input logic fl, input logic [1:0] tp);
    a_d = dd; a_valid = vv; a_en = en; a_flush = fl; a_tap = tp;
  endtask

  // Reference model: the list of samples accepted so far, newest first, DEPTH long.
  logic [8:0] hist[$];

  task automatic model_clear();
    hist = {};
    for (int i = 0; i < 4; i++) hist.push_back(9'd0);
  endtask

  task automatic model_step(input logic [7:0] dd, input logic vv, input logic en, input logic fl);
    if (fl) begin
      model_clear();
    end else if (en) begin
      hist.push_front({dd, vv});
      void'(hist.pop_back());
    end
  endtask

  function automatic logic [8:0] model_tap(input int tap);
    int t;
    t = (tap + 1 > 4) ? 4 : tap + 1;
    return hist[t-1];
  endfunction

  function automatic int model_occ();
    int n;
    n = 0;
    foreach (hist[i]) n += int'(hist[i][0]);
    return n;
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       en;
    logic       fl;
    logic [1:0] tap;
    logic [7:0] exp_op;
    logic       exp_v;
  } vec_t;

  vec_t vecs[10];

  logic [7:0] rd;
  logic       rv, ren, rfl;
  logic [1:0] rtap;
  logic [8:0] expa;
  logic       bq_d[$];
  logic       bq_v[$];

  initial begin
    vecs[0] = '{8'h11, 1'b1, 1'b1, 1'b0, 2'd0, 8'h11, 1'b1};
    vecs[1] = '{8'h22, 1'b1, 1'b1, 1'b0, 2'd1, 8'h11, 1'b1};
    vecs[2] = '{8'h33, 1'b1, 1'b1, 1'b0, 2'd2, 8'h11, 1'b1};
    vecs[3] = '{8'h44, 1'b1, 1'b1, 1'b0, 2'd3, 8'h11, 1'b1};
    vecs[4] = '{8'h55, 1'b0, 1'b1, 1'b0, 2'd3, 8'h22, 1'b1};
    vecs[5] = '{8'h66, 1'b1, 1'b0, 1'b0, 2'd0, 8'h55, 1'b0};
    vecs[6] = '{8'h77, 1'b1, 1'b1, 1'b1, 2'd3, 8'h00, 1'b0};
    vecs[7] = '{8'h88, 1'b1, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0};
    vecs[8] = '{8'h99, 1'b1, 1'b1, 1'b0, 2'd1, 8'h88, 1'b1};
    vecs[9] = '{8'hAA, 1'b1, 1'b0, 1'b0, 2'd0, 8'h99, 1'b1};

    reset_n = 1'b0;
    drive_a(8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    b_d = 1'b0; b_valid = 1'b0; b_en = 1'b0; b_flush = 1'b0; b_tap = 2'd2;
    #1;
    chk("reset a_op", 32'(a_op), 0);
    chk("reset a_op_valid", 32'(a_op_valid), 0);
    chk("reset b_op_valid", 32'(b_op_valid), 0);
    #8 reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive_a(vecs[i].d, vecs[i].v, vecs[i].en, vecs[i].fl, vecs[i].tap);
      tick();
      chk($sformatf("vec%0d op", i), 32'(a_op), 32'(vecs[i].exp_op));
      chk($sformatf("vec%0d op_valid", i), 32'(a_op_valid), 32'(vecs[i].exp_v));
    end

    // Latency sweep: sample n appears at tap t after edge n+t.
    for (int tap = 0; tap < 4; tap++) begin
      drive_a(8'h00, 1'b0, 1'b1, 1'b1, 2'(tap));
      tick();
      for (int n = 0; n < 4; n++) begin
        drive_a(8'(8'h11 * (n + 1)), 1'b1, 1'b1, 1'b0, 2'(tap));
        tick();
        chk($sformatf("sweep tap%0d edge%0d op", tap, n), 32'(a_op),
            (n >= tap) ? 32'(8'(8'h11 * (n - tap + 1))) : 32'd0);
        chk($sformatf("sweep tap%0d edge%0d valid", tap, n), 32'(a_op_valid),
            (n >= tap) ? 32'd1 : 32'd0);
      end
    end

    // Stall: two disabled edges push the A5 sample out by two.
    drive_a(8'h00, 1'b0, 1'b0, 1'b1, 2'd1); tick();
    drive_a(8'hA5, 1'b1, 1'b1, 1'b0, 2'd1); tick();
    chk("stall edge0 valid", 32'(a_op_valid), 0);
    drive_a(8'hFF, 1'b1, 1'b0, 1'b0, 2'd1); tick();
    chk("stall edge1 valid", 32'(a_op_valid), 0);
    tick();
    chk("stall edge2 valid", 32'(a_op_valid), 0);
    drive_a(8'h00, 1'b0, 1'b1, 1'b0, 2'd1); tick();
    chk("stall edge3 op", 32'(a_op), 32'hA5);
    chk("stall edge3 valid", 32'(a_op_valid), 1);

    // Flush beats enable: the 5A sample is dropped and every tap is empty.
    for (int i = 0; i < 4; i++) begin
      drive_a(8'(i + 1), 1'b1, 1'b1, 1'b0, 2'd3); tick();
    end
    chk("full pipe valid", 32'(a_op_valid), 1);
    drive_a(8'h5A, 1'b1, 1'b1, 1'b1, 2'd0); tick();
    a_en = 1'b0; a_flush = 1'b0;
    for (int t = 0; t < 4; t++) begin
      a_tap = 2'(t);
      #1;
      chk($sformatf("flush tap%0d op", t), 32'(a_op), 0);
      chk($sformatf("flush tap%0d valid", t), 32'(a_op_valid), 0);
    end

    // Asynchronous reset between edges with a full pipe.
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      drive_a(8'(8'hC0 + i), 1'b1, 1'b1, 1'b0, 2'd3); tick();
    end
    chk("prereset valid", 32'(a_op_valid), 1);
    #2 reset_n = 1'b0;
    for (int t = 0; t < 4; t++) begin
      a_tap = 2'(t);
      #1;
      chk($sformatf("async reset tap%0d op", t), 32'(a_op), 0);
      chk($sformatf("async reset tap%0d valid", t), 32'(a_op_valid), 0);
    end
`ifdef SHIFT_PIPELINE_OCCUPANCY_EN
    chk("async reset occupancy", 32'(a_occ), 0);
`endif
    #1 reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_a(8'h00, 1'b0, 1'b1, 1'b0, 2'd0); tick();
      chk($sformatf("post reset %0d op", i), 32'(a_op), 0);
      chk($sformatf("post reset %0d valid", i), 32'(a_op_valid), 0);
      a_tap = 2'd3; #1;
      chk($sformatf("post reset %0d tap3 valid", i), 32'(a_op_valid), 0);
    end

`ifdef SHIFT_PIPELINE_OCCUPANCY_EN
    begin
      logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      int   occ [6] = '{1, 2, 2, 3, 3, 3};
      drive_a(8'h00, 1'b0, 1'b0, 1'b1, 2'd0); tick();
      for (int i = 0; i < 6; i++) begin
        drive_a(8'(i), pat[i], 1'b1, 1'b0, 2'd0); tick();
        chk($sformatf("occupancy step%0d", i), 32'(a_occ), 32'(occ[i]));
      end
      drive_a(8'h00, 1'b1, 1'b1, 1'b1, 2'd0); tick();
      chk("occupancy flush", 32'(a_occ), 0);
    end
`endif

    // Randomised run against the reference model; u_b runs as the legacy 3-cycle delay.
    drive_a(8'h00, 1'b0, 1'b0, 1'b1, 2'd0); tick();
    model_clear();
    for (int i = 0; i < 400; i++) begin
      rd   = 8'($urandom);
      rv   = 1'($urandom_range(0, 1));
      ren  = ($urandom_range(0, 3) != 0);
      rfl  = ($urandom_range(0, 19) == 0);
      rtap = 2'($urandom_range(0, 3));
      drive_a(rd, rv, ren, rfl, rtap);
      b_d = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      b_en = 1'b1;
      b_tap = (i % 2 == 1) ? 2'd2 : 2'd3;
      bq_d.push_back(b_d);
      bq_v.push_back(b_valid);
      tick();
      model_step(rd, rv, ren, rfl);
      expa = model_tap(int'(rtap));
      chk($sformatf("rand%0d a_op", i), 32'(a_op), 32'(expa[8:1]));
      chk($sformatf("rand%0d a_op_valid", i), 32'(a_op_valid), 32'(expa[0]));
`ifdef SHIFT_PIPELINE_OCCUPANCY_EN
      chk($sformatf("rand%0d a_occupancy", i), 32'(a_occ), 32'(model_occ()));
`endif
      if (bq_d.size() >= 3) begin
        chk($sformatf("legacy%0d b_op", i), 32'(b_op), 32'(bq_d[bq_d.size()-3]));
        chk($sformatf("legacy%0d b_op_valid", i), 32'(b_op_valid), 32'(bq_v[bq_v.size()-3]));
      end else begin
        chk($sformatf("legacy%0d b_op fill", i), 32'(b_op), 0);
        chk($sformatf("legacy%0d b_op_valid fill", i), 32'(b_op_valid), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
